// File: rtl/mul_div_pkg.sv
// Shared types for the multiply/divide unit: RV32M op encoding and the
// sequential multiplier FSM state type.
package mul_div_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ITER = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mul_state_e;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ACC_W   = 2 * XLEN;
    localparam logic [3:0]  CNT_MAX = 4'd15;

    // Absolute value; -2^31 maps onto its own bit pattern, 0x80000000.
    function automatic logic [XLEN-1:0] mag32(input logic [XLEN-1:0] v,
                                              input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mul32_seq_ctrl_wallace8x8.sv
// 8x8 unsigned combinational multiplier shared by every ITER step.
module wallace8x8 (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);

    always_comb begin
        p_o = '0;
        for (int k = 0; k < 8; k++) begin
            p_o = p_o + ({8'b0, a_i & {8{b_i[k]}}} << k);
        end
    end

endmodule

// File: rtl/mul32_seq_ctrl.sv
// Sequential 32x32 RV32M multiplier: sign-magnitude operands, sixteen
// byte-by-byte steps through one 8x8 multiplier, then sign fix-up.
//
// state | meaning
// IDLE  | ready for a new operation
// ITER  | accumulating byte partial products, cnt 0..15
// FIX   | negate accumulator if needed, register selected half
// DONE  | one-cycle done_o pulse
module mul32_seq_ctrl
    import mul_div_pkg::*;
#(
    parameter int unsigned ZERO_SKIP = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        kill_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    mul_state_e        state_q,  state_d;
    logic [3:0]        cnt_q,    cnt_d;
    logic [ACC_W-1:0]  acc_q,    acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    mul_op_e           op_q,     op_d;
    logic [XLEN-1:0]   a_mag_q,  a_mag_d;
    logic [XLEN-1:0]   b_mag_q,  b_mag_d;
    logic              sign_q,   sign_d;

    logic [7:0]        a_byte;
    logic [7:0]        b_byte;
    logic [15:0]       pp;
    logic [2:0]        ij_sum;
    logic [5:0]        shamt;
    logic [ACC_W-1:0]  acc_fixed;
    logic              a_signed;
    logic              b_signed;
    mul_op_e           op_in;

    assign a_byte = a_mag_q[{cnt_q[3:2], 3'b000} +: 8];
    assign b_byte = b_mag_q[{cnt_q[1:0], 3'b000} +: 8];
    assign ij_sum = {1'b0, cnt_q[3:2]} + {1'b0, cnt_q[1:0]};
    assign shamt  = {ij_sum, 3'b000};

    wallace8x8 u_wallace8x8 (
        .a_i (a_byte),
        .b_i (b_byte),
        .p_o (pp)
    );

    assign op_in     = mul_op_e'(op_i);
    assign a_signed  = (op_in == OP_MULH) || (op_in == OP_MULHSU);
    assign b_signed  = (op_in == OP_MULH);
    assign acc_fixed = sign_q ? (~acc_q + 1'b1) : acc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            op_q     <= OP_MUL;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            op_q     <= op_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            sign_q   <= sign_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        op_d     = op_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        sign_d   = sign_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !kill_i) begin
                    op_d    = op_in;
                    a_mag_d = mag32(a_i, a_signed);
                    b_mag_d = mag32(b_i, b_signed);
                    sign_d  = (a_signed & a_i[31]) ^ (b_signed & b_i[31]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    if ((ZERO_SKIP != 0) && ((a_i == '0) || (b_i == '0))) begin
                        result_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_ITER;
                    end
                end
            end
            ST_ITER: begin
                acc_d = acc_q + ({48'b0, pp} << shamt);
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_MAX) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d = (op_q == OP_MUL) ? acc_fixed[31:0] : acc_fixed[63:32];
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush wins everywhere and must leave the previous result visible.
        if (kill_i) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Self-checking bench for mul32_seq_ctrl: directed RV32M corner cases,
// randomized ops against a 64-bit arithmetic model, kill and reset aborts.
module tb_mul32_seq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        kill_i;
    logic        ready_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    mul32_seq_ctrl #(.ZERO_SKIP(1)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .kill_i   (kill_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint av;
        longint bv;
        longint p;
        av = (op == 2'b01 || op == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
        bv = (op == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
        p  = av * bv;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Advances negedge by negedge until done_o or the budget runs out (returns 99).
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (done_o !== 1'b1 && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
        if (done_o !== 1'b1) lat = 99;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string name);
        logic [31:0] exp;
        int exp_lat;
        int lat;
        exp     = ref_mul(op, a, b);
        exp_lat = (a == 32'd0 || b == 32'd0) ? 1 : 18;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_before: got %b want 1", name, ready_o);
        end
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(negedge clk_i);
        start_i = 1'b0; a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
        wait_done(1, lat);
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (result_o !== exp) begin
            failures++;
            $display("FAIL %s result: got %h want %h (op=%0d a=%h b=%h)",
                     name, result_o, exp, op, a, b);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || ready_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: got done=%b ready=%b busy=%b want 0 1 0",
                     name, done_o, ready_o, busy_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; start_i = 1'b1; kill_i = 1'b1; op_i = 2'b00;
        a_i = 32'd3; b_i = 32'd5;
        repeat (2) @(negedge clk_i);
        start_i = 1'b0; kill_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: got ready=%b busy=%b done=%b result=%h want 1 0 0 0",
                     ready_o, busy_o, done_o, result_o);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_directed();
        run_op(2'b00, 32'd7,         32'd6,         "mul_7x6");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_m1");
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "mul_min");
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, "mulh_minmin");
        run_op(2'b11, 32'h0000_0000, 32'h0000_1234, "zero_skip");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_op(2'($urandom), pick_operand(), pick_operand(), "random");
        end
    endtask

    task automatic test_kill_iter();
        logic [31:0] prev;
        int seen;
        run_op(2'b00, 32'h1234_5678, 32'h0000_0003, "kill_setup");
        prev = result_o;
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b11; a_i = 32'hDEAD_BEEF; b_i = 32'h1357_9BDF;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        kill_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL kill_iter_idle: got ready=%b busy=%b done=%b want 1 0 0",
                     ready_o, busy_o, done_o);
        end
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            if (done_o === 1'b1) seen++;
            @(negedge clk_i);
        end
        checks++;
        if (seen != 0 || result_o !== prev) begin
            failures++;
            $display("FAIL kill_iter_result: got done_cnt=%0d result=%h want 0 %h",
                     seen, result_o, prev);
        end
    endtask

    task automatic test_kill_start_idle();
        int seen;
        @(negedge clk_i);
        start_i = 1'b1; kill_i = 1'b1; op_i = 2'b00; a_i = 32'd9; b_i = 32'd9;
        @(negedge clk_i);
        start_i = 1'b0; kill_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL kill_start_idle: got ready=%b busy=%b want 1 0", ready_o, busy_o);
        end
        seen = 0;
        for (int c = 0; c < 22; c++) begin
            if (done_o === 1'b1) seen++;
            @(negedge clk_i);
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL kill_start_nodone: got done_cnt=%0d want 0", seen);
        end
    endtask

    task automatic test_kill_done();
        int lat;
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b00; a_i = 32'd1000; b_i = 32'd1000;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done(1, lat);
        kill_i = 1'b1;
        checks++;
        if (lat != 18) begin
            failures++;
            $display("FAIL kill_done_latency: got %0d want 18", lat);
        end
        @(negedge clk_i);
        kill_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || done_o !== 1'b0 || result_o !== 32'd1000000) begin
            failures++;
            $display("FAIL kill_done_state: got ready=%b done=%b result=%h want 1 0 %h",
                     ready_o, done_o, result_o, 32'd1000000);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] exp;
        exp = ref_mul(2'b01, 32'hFFFF_FFF0, 32'h0001_0001);
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b01; a_i = 32'hFFFF_FFF0; b_i = 32'h0001_0001;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b11; a_i = 32'hAAAA_5555; b_i = 32'h0F0F_F0F0;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done(4, lat);
        checks++;
        if (lat != 18 || result_o !== exp) begin
            failures++;
            $display("FAIL ignore_start: got lat=%0d result=%h want 18 %h", lat, result_o, exp);
        end
        @(negedge clk_i);
        run_op(2'b11, 32'hAAAA_5555, 32'h0F0F_F0F0, "back_to_back");
    endtask

    task automatic test_reset_midflight();
        int seen;
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b00; a_i = 32'd77; b_i = 32'd88;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (7) @(negedge clk_i);
        rst_ni = 1'b0; start_i = 1'b1; kill_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1; start_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_midflight: got ready=%b busy=%b done=%b result=%h want 1 0 0 0",
                     ready_o, busy_o, done_o, result_o);
        end
        seen = 0;
        for (int c = 0; c < 22; c++) begin
            if (done_o === 1'b1) seen++;
            @(negedge clk_i);
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_nodone: got done_cnt=%0d want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_kill_iter();
        test_kill_start_idle();
        test_kill_done();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul32_seq_ctrl.md
MUL32_SEQ_CTRL -- requirements
Module: mul32_seq_ctrl

Interface
REQ-001 SHALL have parameter ZERO_SKIP, default 1; when 1, a zero operand bypasses iteration.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start_i  input  1  request a multiply; sampled only when ready_o=1.
REQ-005 SHALL have port op_i  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (RV32M funct3[1:0]).
REQ-006 SHALL have port a_i  input  32  rs1 operand.
REQ-007 SHALL have port b_i  input  32  rs2 operand.
REQ-008 SHALL have port kill_i  input  1  pipeline flush; aborts any operation.
REQ-009 SHALL have port ready_o  output  1  controller idle; a start is accepted.
REQ-010 SHALL have port busy_o  output  1  operation in flight (not IDLE).
REQ-011 SHALL have port done_o  output  1  one-cycle pulse; result_o valid.
REQ-012 SHALL have port result_o  output  32  selected product half; held until next accept.

Function
REQ-013 SHALL implement FSM states IDLE, ITER, FIX, DONE; ready_o=1 only in IDLE; busy_o=1 in ITER, FIX and DONE.
REQ-014 SHALL, in IDLE with start_i=1 and kill_i=0, capture op, operand magnitudes, and result sign, then go to ITER.
REQ-015 SHALL take magnitudes: a signed for MULH/MULHSU, b signed for MULH only; -2^31 yields magnitude 0x80000000.
REQ-016 SHALL set result sign = XOR of the signs of the operands treated as signed.
REQ-017 SHALL, in ITER, use 4-bit counter cnt 0..15: i=cnt[3:2] selects byte of |a|, j=cnt[1:0] selects byte of |b|.
REQ-018 SHALL feed one byte pair per cycle to a single shared 8x8 unsigned multiplier instance.
REQ-019 SHALL accumulate each 16-bit partial product into a 64-bit accumulator shifted left by 8*(i+j).
REQ-020 SHALL clear the accumulator on accept and move ITER->FIX after cnt=15.
REQ-021 SHALL, in FIX, two's-complement-negate the 64-bit accumulator if sign=1.
REQ-022 SHALL, in FIX, register result_o = low 32 bits for MUL, else high 32 bits; then go to DONE.
REQ-023 SHALL assert done_o only in DONE, for exactly one cycle, then return to IDLE.
REQ-024 SHALL give latency: done_o high in the 18th cycle after the accepting edge (16 ITER + FIX + DONE).
REQ-025 SHALL, when ZERO_SKIP=1 and a_i=0 or b_i=0 at accept, go IDLE->DONE with result_o=0, done_o in the 1st cycle after accept.
REQ-026 SHALL ignore start_i outside IDLE; captured operands are unaffected.
REQ-027 SHALL, on kill_i=1 in any state, go to IDLE next cycle, with no done_o for the aborted operation and result_o unchanged.
REQ-028 SHALL treat kill_i=1 together with start_i=1 in IDLE as no accept.
REQ-029 SHALL give kill_i in DONE priority: done_o is still high that cycle, and the FSM returns to IDLE.

Reset
REQ-030 SHALL, when rst_ni=0 at a rising edge, set state=IDLE, cnt=0, accumulator=0, result_o=0, done_o=0, ready_o=1, busy_o=0.
REQ-031 SHALL abort any in-flight operation on reset, with no done_o.
REQ-032 SHALL take rst_ni over kill_i and start_i.

Structure
REQ-033 SHALL place the op encoding (MUL/MULH/MULHSU/MULHU) and the FSM state type in the shared mul_div package.
REQ-034 SHALL instantiate exactly one sub-module, wallace8x8 (8x8 unsigned -> 16-bit), combinationally in the ITER path.
REQ-035 SHALL register all outputs; no combinational input-to-output path.

Verification
REQ-036 SHALL check: MUL a=7 b=6 -> result_o=0x0000002A, done_o exactly 18 cycles after accept.
REQ-037 SHALL check: MULH a=0xFFFFFFFF b=0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE.
REQ-038 SHALL check: MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF; MUL a=0x80000000 b=0xFFFFFFFF -> 0x80000000.
REQ-039 SHALL check: ZERO_SKIP=1, MULHU a=0 b=0x1234 -> result_o=0, done_o 1 cycle after accept.
REQ-040 SHALL check: kill_i at cycle 5 of ITER -> no done_o, ready_o=1 next cycle, result_o retains the prior value.
REQ-041 SHALL check: start_i with new operands during ITER -> ignored, and the original product is returned.
